watch_time_counter: RTL



---
 rtl/watch_time_counter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/watch_time_counter.sv
// watch_time_counter: free-running calendar/time-of-day counter on a 1 Hz clock.
// Loads a packed time word from the set-mode stage through a level req / pulse
// ack handshake; illegal words are rejected with set_err and the clock keeps
// ticking.
//
// Ports:
//   clk1sec      in   1 Hz tick clock, rising edge
//   rst          in   asynchronous active-low reset
//   set_req      in   load request level, held until set_ack/set_err
//   set_time     in   {year[51:40],month[39:32],day[31:24],hour[23:16],minute[15:8],second[7:0]}
//   set_ack      out  one-cycle pulse, word accepted and loaded
//   set_err      out  one-cycle pulse, word rejected
//   year..second out  current time (registered)
//   day_tick     out  one-cycle pulse on the 23:59:59 -> 00:00:00 edge
//
// Optional feature macro WATCH_ALARM_EN adds alarm_on, alarm_hour,
// alarm_minute inputs and the alarm_hit output pulse.
module watch_time_counter #(
   parameter int unsigned YEAR_RST  = 2000,
   parameter int unsigned MONTH_RST = 1,
   parameter int unsigned DAY_RST   = 1,
   parameter int unsigned HOUR_RST  = 0
) (
   input  logic        clk1sec,
   input  logic        rst,
   input  logic        set_req,
   input  logic [51:0] set_time,
`ifdef WATCH_ALARM_EN
   input  logic        alarm_on,
   input  logic [7:0]  alarm_hour,
   input  logic [7:0]  alarm_minute,
   output logic        alarm_hit,
`endif
   output logic        set_ack,
   output logic        set_err,
   output logic [11:0] year,
   output logic [7:0]  month,
   output logic [7:0]  day,
   output logic [7:0]  hour,
   output logic [7:0]  minute,
   output logic [7:0]  second,
   output logic        day_tick
);

   localparam int unsigned YW = 12;
   localparam int unsigned FW = 8;

   typedef enum logic {
      ARMED    = 1'b0,
      WAIT_LOW = 1'b1
   } hs_state_t;

   hs_state_t state;

   // Gregorian leap-year rule.
   function automatic logic is_leap(input logic [YW-1:0] y);
      return ((y[1:0] == 2'b00) && ((y % 12'd100) != 12'd0)) ||
             ((y % 12'd400) == 12'd0);
   endfunction

   // Last day of month m in year y.
   function automatic logic [FW-1:0] max_date(input logic [FW-1:0] m,
                                              input logic [YW-1:0] y);
      logic [FW-1:0] r;
      case (m)
         8'd4, 8'd6, 8'd9, 8'd11: r = 8'd30;
         8'd2:                    r = is_leap(y) ? 8'd29 : 8'd28;
         default:                 r = 8'd31;
      endcase
      return r;
   endfunction

   // Fields of the word offered for loading.
   logic [YW-1:0] ld_year_c;
   logic [FW-1:0] ld_month_c, ld_day_c, ld_hour_c, ld_minute_c, ld_second_c;
   logic          legal_c;

   assign ld_year_c   = set_time[51:40];
   assign ld_month_c  = set_time[39:32];
   assign ld_day_c    = set_time[31:24];
   assign ld_hour_c   = set_time[23:16];
   assign ld_minute_c = set_time[15:8];
   assign ld_second_c = set_time[7:0];

   // Day limit is taken from the offered month/year, not the running ones.
   assign legal_c = (ld_year_c != 12'd0) &&
                    (ld_month_c >= 8'd1) && (ld_month_c <= 8'd12) &&
                    (ld_day_c >= 8'd1) &&
                    (ld_day_c <= max_date(ld_month_c, ld_year_c)) &&
                    (ld_hour_c <= 8'd23) &&
                    (ld_minute_c <= 8'd59) &&
                    (ld_second_c <= 8'd59);

   // Normal one-second increment with the full carry chain.
   logic [YW-1:0] inc_year_c;
   logic [FW-1:0] inc_month_c, inc_day_c, inc_hour_c, inc_minute_c, inc_second_c;
   logic          rollover_c;

   always_comb begin
      inc_year_c   = year;
      inc_month_c  = month;
      inc_day_c    = day;
      inc_hour_c   = hour;
      inc_minute_c = minute;
      inc_second_c = second + 8'd1;
      rollover_c   = 1'b0;
      if (second == 8'd59) begin
         inc_second_c = 8'd0;
         inc_minute_c = minute + 8'd1;
         if (minute == 8'd59) begin
            inc_minute_c = 8'd0;
            inc_hour_c   = hour + 8'd1;
            if (hour == 8'd23) begin
               inc_hour_c = 8'd0;
               rollover_c = 1'b1;
               inc_day_c  = day + 8'd1;
               if (day == max_date(month, year)) begin
                  inc_day_c   = 8'd1;
                  inc_month_c = month + 8'd1;
                  if (month == 8'd12) begin
                     inc_month_c = 8'd1;
                     // There is no year zero: 4095 wraps to 1.
                     inc_year_c  = (year == 12'd4095) ? 12'd1 : year + 12'd1;
                  end
               end
            end
         end
      end
   end

   // Handshake decode; a load overrides the tick on the same edge.
   logic load_c, err_c;

   assign load_c = (state == ARMED) && set_req && legal_c;
   assign err_c  = (state == ARMED) && set_req && !legal_c;

   logic [YW-1:0] nxt_year_c;
   logic [FW-1:0] nxt_month_c, nxt_day_c, nxt_hour_c, nxt_minute_c, nxt_second_c;

   always_comb begin
      nxt_year_c   = inc_year_c;
      nxt_month_c  = inc_month_c;
      nxt_day_c    = inc_day_c;
      nxt_hour_c   = inc_hour_c;
      nxt_minute_c = inc_minute_c;
      nxt_second_c = inc_second_c;
      if (load_c) begin
         nxt_year_c   = ld_year_c;
         nxt_month_c  = ld_month_c;
         nxt_day_c    = ld_day_c;
         nxt_hour_c   = ld_hour_c;
         nxt_minute_c = ld_minute_c;
         nxt_second_c = ld_second_c;
      end
   end

   // Time registers, handshake FSM and output pulses.
   always_ff @(posedge clk1sec or negedge rst) begin
      if (!rst) begin
         state    <= ARMED;
         year     <= YW'(YEAR_RST);
         month    <= FW'(MONTH_RST);
         day      <= FW'(DAY_RST);
         hour     <= FW'(HOUR_RST);
         minute   <= 8'd0;
         second   <= 8'd0;
         set_ack  <= 1'b0;
         set_err  <= 1'b0;
         day_tick <= 1'b0;
      end else begin
         year     <= nxt_year_c;
         month    <= nxt_month_c;
         day      <= nxt_day_c;
         hour     <= nxt_hour_c;
         minute   <= nxt_minute_c;
         second   <= nxt_second_c;
         set_ack  <= load_c;
         set_err  <= err_c;
         day_tick <= rollover_c && !load_c;
         case (state)
            ARMED:    if (set_req)  state <= WAIT_LOW;
            WAIT_LOW: if (!set_req) state <= ARMED;
            default:  state <= ARMED;
         endcase
      end
   end

`ifdef WATCH_ALARM_EN
   // Fires when the time about to be registered is alarm_hour:alarm_minute:00.
   always_ff @(posedge clk1sec or negedge rst) begin
      if (!rst) begin
         alarm_hit <= 1'b0;
      end else begin
         alarm_hit <= alarm_on &&
                      (nxt_hour_c == alarm_hour) &&
                      (nxt_minute_c == alarm_minute) &&
                      (nxt_second_c == 8'd0);
      end
   end
`endif

endmodule
